memory_controller: RTL and testbench

//  Responder side of the LSB<->MC data interface, plus the IF instruction-fetch port. Owns the single

---
 rtl/memory_controller.sv | 231 +++++++++++++++++++++++
 tb/tb_memory_controller.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_controller.sv
// Byte-serial controller for the shared RAM/IO bus: LSB loads/stores and IF fetches.
// LSB requests win over fetches; IO-space writes stall while the IO buffer is full.
module memory_controller #(
  parameter logic [1:0] IO_HI       = 2'b11,
  parameter bit         IF_FLUSH_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        lsb_flag,
  input  logic        lsb_r_nw,
  input  logic        load_sign,
  input  logic [1:0]  data_size_to_mc,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_write,
  output logic [31:0] data_read,
  output logic        lsb_enable,
  output logic        data_rdy,
  input  logic        if_flag,
  input  logic [31:0] if_addr,
  input  logic        if_flush,
  output logic [31:0] inst,
  output logic        inst_rdy,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = 8;
  localparam int unsigned KW = 3;

  typedef enum logic [1:0] {S_IDLE, S_LREAD, S_LWRITE, S_IREAD} state_t;

  state_t          r_state, w_state_nxt;
  logic [AW-1:0]   r_addr, w_addr_nxt;
  logic [DW-1:0]   r_wdata, w_wdata_nxt;
  logic [KW-1:0]   r_len, w_len_nxt;
  logic [KW-1:0]   r_k, w_k_nxt;
  logic            r_sign, w_sign_nxt;
  logic [DW-1:0]   r_buf, w_buf_nxt;
  logic [DW-1:0]   r_data_read, w_data_read_nxt;
  logic            r_data_rdy, w_data_rdy_nxt;
  logic [DW-1:0]   r_inst, w_inst_nxt;
  logic            r_inst_rdy, w_inst_rdy_nxt;
  logic [BW-1:0]   r_mem_dout, w_mem_dout_nxt;
  logic [AW-1:0]   r_mem_a, w_mem_a_nxt;
  logic            r_mem_wr, w_mem_wr_nxt;

  logic [KW-1:0]   w_req_len;
  logic [DW-1:0]   w_cap;
  logic [DW-1:0]   w_ext;
  logic [BW-1:0]   w_wbyte;
  logic            w_flush;
  logic            w_io_stall;
  logic            w_io_stall_acc;

  assign w_flush        = IF_FLUSH_EN && if_flush;
  assign w_io_stall     = (r_addr[17:16] == IO_HI) && io_buffer_full;
  assign w_io_stall_acc = (data_addr[17:16] == IO_HI) && io_buffer_full;

  // Request size code to byte count; code 2 behaves as a word.
  always_comb begin
    w_req_len = KW'(4);
    case (data_size_to_mc)
      2'd0:    w_req_len = KW'(1);
      2'd1:    w_req_len = KW'(2);
      default: w_req_len = KW'(4);
    endcase
  end

  // Read buffer with the byte arriving this cycle merged in at position k-1.
  always_comb begin
    w_cap = r_buf;
    case (r_k)
      KW'(1):  w_cap[7:0]   = mem_din;
      KW'(2):  w_cap[15:8]  = mem_din;
      KW'(3):  w_cap[23:16] = mem_din;
      default: w_cap[31:24] = mem_din;
    endcase
  end

  always_comb begin
    w_ext = w_cap;
    case (r_len)
      KW'(1):  w_ext = {{24{r_sign & w_cap[7]}}, w_cap[7:0]};
      KW'(2):  w_ext = {{16{r_sign & w_cap[15]}}, w_cap[15:0]};
      default: w_ext = w_cap;
    endcase
  end

  always_comb begin
    w_wbyte = r_wdata[7:0];
    case (r_k[1:0])
      2'd0:    w_wbyte = r_wdata[7:0];
      2'd1:    w_wbyte = r_wdata[15:8];
      2'd2:    w_wbyte = r_wdata[23:16];
      default: w_wbyte = r_wdata[31:24];
    endcase
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt     = r_state;
    w_addr_nxt      = r_addr;
    w_wdata_nxt     = r_wdata;
    w_len_nxt       = r_len;
    w_k_nxt         = r_k;
    w_sign_nxt      = r_sign;
    w_buf_nxt       = r_buf;
    w_data_read_nxt = r_data_read;
    w_data_rdy_nxt  = 1'b0;
    w_inst_nxt      = r_inst;
    w_inst_rdy_nxt  = 1'b0;
    w_mem_dout_nxt  = r_mem_dout;
    w_mem_a_nxt     = r_mem_a;
    w_mem_wr_nxt    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (lsb_flag) begin
          w_addr_nxt  = data_addr;
          w_wdata_nxt = data_write;
          w_len_nxt   = w_req_len;
          w_sign_nxt  = load_sign;
          if (lsb_r_nw) begin
            w_state_nxt = S_LREAD;
            w_mem_a_nxt = data_addr;
            w_k_nxt     = KW'(1);
          end else begin
            w_state_nxt = S_LWRITE;
            if (w_io_stall_acc) begin
              w_k_nxt = KW'(0);
            end else begin
              w_mem_a_nxt    = data_addr;
              w_mem_dout_nxt = data_write[7:0];
              w_mem_wr_nxt   = 1'b1;
              w_k_nxt        = KW'(1);
            end
          end
        end else if (if_flag && !w_flush) begin
          w_state_nxt = S_IREAD;
          w_addr_nxt  = if_addr;
          w_len_nxt   = KW'(4);
          w_sign_nxt  = 1'b0;
          w_mem_a_nxt = if_addr;
          w_k_nxt     = KW'(1);
        end
      end
      S_LREAD, S_IREAD: begin
        if (r_state == S_IREAD && w_flush) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_buf_nxt = w_cap;
          if (r_k == r_len) begin
            w_state_nxt = S_IDLE;
            if (r_state == S_LREAD) begin
              w_data_read_nxt = w_ext;
              w_data_rdy_nxt  = 1'b1;
            end else begin
              w_inst_nxt     = w_cap;
              w_inst_rdy_nxt = 1'b1;
            end
          end else begin
            w_mem_a_nxt = r_addr + AW'(r_k);
            w_k_nxt     = r_k + KW'(1);
          end
        end
      end
      S_LWRITE: begin
        if (r_k == r_len) begin
          w_state_nxt    = S_IDLE;
          w_data_rdy_nxt = 1'b1;
        end else if (!w_io_stall) begin
          w_mem_a_nxt    = r_addr + AW'(r_k);
          w_mem_dout_nxt = w_wbyte;
          w_mem_wr_nxt   = 1'b1;
          w_k_nxt        = r_k + KW'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State and output registers; rdy low freezes everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_len       <= '0;
      r_k         <= '0;
      r_sign      <= 1'b0;
      r_buf       <= '0;
      r_data_read <= '0;
      r_data_rdy  <= 1'b0;
      r_inst      <= '0;
      r_inst_rdy  <= 1'b0;
      r_mem_dout  <= '0;
      r_mem_a     <= '0;
      r_mem_wr    <= 1'b0;
    end else if (rdy) begin
      r_state     <= w_state_nxt;
      r_addr      <= w_addr_nxt;
      r_wdata     <= w_wdata_nxt;
      r_len       <= w_len_nxt;
      r_k         <= w_k_nxt;
      r_sign      <= w_sign_nxt;
      r_buf       <= w_buf_nxt;
      r_data_read <= w_data_read_nxt;
      r_data_rdy  <= w_data_rdy_nxt;
      r_inst      <= w_inst_nxt;
      r_inst_rdy  <= w_inst_rdy_nxt;
      r_mem_dout  <= w_mem_dout_nxt;
      r_mem_a     <= w_mem_a_nxt;
      r_mem_wr    <= w_mem_wr_nxt;
    end
  end

  assign lsb_enable = (r_state == S_IDLE);
  assign data_read  = r_data_read;
  assign data_rdy   = r_data_rdy;
  assign inst       = r_inst;
  assign inst_rdy   = r_inst_rdy;
  assign mem_dout   = r_mem_dout;
  assign mem_a      = r_mem_a;
  assign mem_wr     = r_mem_wr;

endmodule

// File: tb/tb_memory_controller.sv
// Scoreboard bench for memory_controller: stimulus pushes expected responses and writes,
// a negedge monitor pops and compares them whenever the DUT presents a completion or write.
module tb_memory_controller;

  logic        clk = 1'b0;
  logic        rst, rdy;
  logic        lsb_flag, lsb_r_nw, load_sign;
  logic [1:0]  data_size_to_mc;
  logic [31:0] data_addr, data_write, data_read;
  logic        lsb_enable, data_rdy;
  logic        if_flag, if_flush, inst_rdy;
  logic [31:0] if_addr, inst;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr, io_buffer_full;

  typedef struct { logic chk; logic [31:0] val; int cyc; } exp_t;
  typedef struct { logic [31:0] a; logic [7:0] d; } wr_t;

  exp_t q_data[$];
  exp_t q_inst[$];
  wr_t  q_wr[$];
  exp_t me;
  wr_t  mw;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  logic [7:0] ram [0:4095];

  memory_controller dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .lsb_flag(lsb_flag), .lsb_r_nw(lsb_r_nw), .load_sign(load_sign),
    .data_size_to_mc(data_size_to_mc), .data_addr(data_addr), .data_write(data_write),
    .data_read(data_read), .lsb_enable(lsb_enable), .data_rdy(data_rdy),
    .if_flag(if_flag), .if_addr(if_addr), .if_flush(if_flush),
    .inst(inst), .inst_rdy(inst_rdy),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: byte at the presented address, stalled by rdy; IO space is not backed.
  assign mem_din = ram[mem_a[11:0]];
  always @(posedge clk) begin
    if (rdy && mem_wr && mem_a[17:16] != 2'b11) ram[mem_a[11:0]] = mem_dout;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every completion pulse and every write cycle must match the head of its queue.
  always @(negedge clk) begin
    if (!rst && rdy) begin
      if (data_rdy || inst_rdy) check("rdy_exclusive", 32'(data_rdy & inst_rdy), 32'd0);
      if (data_rdy) begin
        if (q_data.size() == 0) check("data_rdy_unexpected", 32'(data_rdy), 32'd0);
        else begin
          me = q_data.pop_front();
          if (me.chk) check("data_read", data_read, me.val);
          if (me.cyc != 0) check("data_latency", 32'(cyc), 32'(me.cyc));
        end
      end
      if (inst_rdy) begin
        if (q_inst.size() == 0) check("inst_rdy_unexpected", 32'(inst_rdy), 32'd0);
        else begin
          me = q_inst.pop_front();
          check("inst", inst, me.val);
          check("inst_latency", 32'(cyc), 32'(me.cyc));
        end
      end
      if (mem_wr) begin
        if (q_wr.size() == 0) check("mem_wr_unexpected", 32'(mem_wr), 32'd0);
        else begin
          mw = q_wr.pop_front();
          check("wr_addr", mem_a, mw.a);
          check("wr_byte", 32'(mem_dout), 32'(mw.d));
        end
      end
    end
  end

  // Called at posedge+1 in an IDLE cycle; drives a one-cycle LSB request.
  task automatic lsb_issue(input logic rnw, input logic sgn, input logic [1:0] sz,
                           input logic [31:0] a, input logic [31:0] wd,
                           input logic exp_rdy, input logic chk, input logic [31:0] ev,
                           input int lat);
    check("lsb_enable_before_req", 32'(lsb_enable), 32'd1);
    lsb_flag = 1'b1; lsb_r_nw = rnw; load_sign = sgn;
    data_size_to_mc = sz; data_addr = a; data_write = wd;
    if (exp_rdy) q_data.push_back('{chk, ev, (lat == 0) ? 0 : cyc + lat});
    @(posedge clk); #1;
    lsb_flag = 1'b0;
  endtask

  task automatic fetch_run(input logic [31:0] a, input logic [31:0] v);
    q_inst.push_back('{1'b1, v, cyc + 5});
    if_addr = a; if_flag = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (inst_rdy) break;
    end
    if_flag = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while ((q_data.size() + q_inst.size() + q_wr.size()) != 0 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, 32'(q_data.size() + q_inst.size() + q_wr.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
    ram[12'h100] = 8'h80;
    ram[12'h010] = 8'h34; ram[12'h011] = 8'h92;
    ram[12'h000] = 8'h13; ram[12'h001] = 8'h05; ram[12'h002] = 8'h00; ram[12'h003] = 8'h00;
    ram[12'h040] = 8'h93; ram[12'h041] = 8'h00; ram[12'h042] = 8'h10; ram[12'h043] = 8'h00;

    rst = 1'b1; rdy = 1'b1;
    lsb_flag = 1'b0; lsb_r_nw = 1'b0; load_sign = 1'b0; data_size_to_mc = 2'd0;
    data_addr = '0; data_write = '0; if_flag = 1'b0; if_addr = '0; if_flush = 1'b0;
    io_buffer_full = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data_rdy", 32'(data_rdy), 32'd0);
    check("rst_inst_rdy", 32'(inst_rdy), 32'd0);
    check("rst_mem_wr", 32'(mem_wr), 32'd0);
    check("rst_mem_a", mem_a, 32'd0);
    check("rst_mem_dout", 32'(mem_dout), 32'd0);
    check("rst_data_read", data_read, 32'd0);
    check("rst_inst", inst, 32'd0);
    check("rst_lsb_enable", 32'(lsb_enable), 32'd1);
    rst = 1'b0;

    // LB / LBU of 0x80
    lsb_issue(1'b1, 1'b1, 2'd0, 32'h100, 32'h0, 1'b1, 1'b1, 32'hFFFF_FF80, 2);
    wait_done("lb_done");
    lsb_issue(1'b1, 1'b0, 2'd0, 32'h100, 32'h0, 1'b1, 1'b1, 32'h0000_0080, 2);
    wait_done("lbu_done");

    // SW then LW of the same word
    q_wr.push_back('{32'h200, 8'hEF});
    q_wr.push_back('{32'h201, 8'hBE});
    q_wr.push_back('{32'h202, 8'hAD});
    q_wr.push_back('{32'h203, 8'hDE});
    lsb_issue(1'b0, 1'b0, 2'd3, 32'h200, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0, 5);
    wait_done("sw_done");
    lsb_issue(1'b1, 1'b0, 2'd3, 32'h200, 32'h0, 1'b1, 1'b1, 32'hDEAD_BEEF, 5);
    wait_done("lw_done");

    // LH and fetch requested together: LH first, fetch accepted in the data_rdy cycle
    q_inst.push_back('{1'b1, 32'h0000_0513, cyc + 8});
    if_addr = 32'h0; if_flag = 1'b1;
    lsb_issue(1'b1, 1'b1, 2'd1, 32'h10, 32'h0, 1'b1, 1'b1, 32'hFFFF_9234, 3);
    for (int i = 0; i < 20; i++) begin
      if (inst_rdy) break;
      @(posedge clk); #1;
    end
    if_flag = 1'b0;
    wait_done("lh_fetch_done");

    // IO-space SB held off by io_buffer_full for three cycles
    io_buffer_full = 1'b1;
    q_wr.push_back('{32'h0003_0000, 8'h41});
    lsb_issue(1'b0, 1'b0, 2'd0, 32'h0003_0000, 32'h0000_0041, 1'b1, 1'b0, 32'h0, 5);
    check("io_stall_wr_1", 32'(mem_wr), 32'd0);
    @(posedge clk); #1;
    check("io_stall_wr_2", 32'(mem_wr), 32'd0);
    @(posedge clk); #1;
    check("io_stall_wr_3", 32'(mem_wr), 32'd0);
    io_buffer_full = 1'b0;
    wait_done("io_sb_done");

    // Flush on the second byte of a fetch, then a fresh fetch at 0x40
    if_addr = 32'h0; if_flag = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("flush_mem_a_byte1", mem_a, 32'h1);
    if_flush = 1'b1; if_flag = 1'b0;
    @(posedge clk); #1;
    if_flush = 1'b0;
    check("flush_lsb_enable", 32'(lsb_enable), 32'd1);
    check("flush_no_inst_rdy", 32'(inst_rdy), 32'd0);
    fetch_run(32'h40, 32'h0010_0093);
    wait_done("refetch_done");

    // Flush coinciding with fetch completion suppresses inst_rdy
    if_addr = 32'h0; if_flag = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    if_flush = 1'b1; if_flag = 1'b0;
    @(posedge clk); #1;
    if_flush = 1'b0;
    check("flush_last_no_inst_rdy", 32'(inst_rdy), 32'd0);
    check("flush_last_idle", 32'(lsb_enable), 32'd1);
    repeat (4) begin @(posedge clk); #1; end

    // rdy low freezes an LW for three cycles
    lsb_issue(1'b1, 1'b0, 2'd3, 32'h200, 32'h0, 1'b1, 1'b1, 32'hDEAD_BEEF, 8);
    rdy = 1'b0;
    @(posedge clk); #1;
    check("freeze_mem_a", mem_a, 32'h200);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rdy = 1'b1;
    wait_done("freeze_lw_done");

    // Reset in the middle of an LW drops it
    lsb_issue(1'b1, 1'b0, 2'd3, 32'h200, 32'h0, 1'b0, 1'b0, 32'h0, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_data_rdy", 32'(data_rdy), 32'd0);
    check("midrst_mem_a", mem_a, 32'd0);
    check("midrst_mem_wr", 32'(mem_wr), 32'd0);
    check("midrst_data_read", data_read, 32'd0);
    check("midrst_inst", inst, 32'd0);
    check("midrst_lsb_enable", 32'(lsb_enable), 32'd1);
    rst = 1'b0;
    repeat (8) begin @(posedge clk); #1; end
    wait_done("final_queues_empty");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
